packet_record_parser: RTL and testbench

//  Parametrised successor to the fixed 32-bit packet header handling: consumes the packet buffer

---
 rtl/packet_record_parser_if.sv | 28 ++
 rtl/packet_record_parser.sv | 114 +++++++++++
 tb/tb_packet_record_parser.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_record_parser_if.sv
// Record-in / AXI-Stream-out bundle for packet_record_parser.
// slave = parser view (consumes s_*, drives m_*); master = environment view.
interface packet_record_parser_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NUM_IF = 4
);
  localparam int unsigned DEST_W = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;

  logic [DATA_W-1:0]   s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic [DATA_W-1:0]   m_tdata;
  logic [DATA_W/8-1:0] m_tkeep;
  logic                m_tlast;
  logic [DEST_W-1:0]   m_tdest;
  logic                m_tvalid;
  logic                m_tready;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tlast, m_tdest, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tlast, m_tdest, m_tvalid
  );
endinterface

// File: rtl/packet_record_parser.sv
// Splits a header+payload record stream into per-interface AXI-Stream packets, dropping bad records.
// Optional PARSER_STRIP_FCS_EN: strip the trailing 4-byte FCS from forwarded packets.
module packet_record_parser #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned NUM_IF  = 4,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                         clk,
  input  logic                         rst,
  packet_record_parser_if.slave        bus,
  output logic [31:0]                  pkt_count,
  output logic [31:0]                  drop_count
);
  localparam int unsigned B      = DATA_W / 8;
  localparam int unsigned DEST_W = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;

  typedef enum logic [1:0] {StHdr, StPay, StDrop} state_e;

  state_e       state_q;
  logic [15:0]  rem_q;
  logic [15:0]  id_q;

  logic [15:0]  hdr_len;
  logic [15:0]  hdr_id;
  logic         hdr_ok;
  logic         accept;
  logic         last_in;
  logic [15:0]  out_rem;
  logic         out_has;
  logic [B-1:0] keep_calc;

  assign hdr_len = bus.s_tdata[31:16];
  assign hdr_id  = bus.s_tdata[15:0];
  assign hdr_ok  = ({16'd0, hdr_len} >= MIN_LEN) && ({16'd0, hdr_len} <= MAX_LEN) &&
                   ({16'd0, hdr_id} < NUM_IF);

  // Header and drop words never occupy the output register, so only payload waits on it.
  assign bus.s_tready = !rst && ((state_q != StPay) || !bus.m_tvalid || bus.m_tready);
  assign accept       = bus.s_tvalid && bus.s_tready;
  assign last_in      = ({16'd0, rem_q} <= B);

`ifdef PARSER_STRIP_FCS_EN
  // out_rem wraps once only FCS bytes remain; out_has masks those words.
  assign out_rem = rem_q - 16'd4;
  assign out_has = (rem_q > 16'd4);
`else
  assign out_rem = rem_q;
  assign out_has = 1'b1;
`endif

  always_comb begin
    keep_calc = '0;
    for (int unsigned i = 0; i < B; i++) begin
      keep_calc[i] = ({16'd0, out_rem} > i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StHdr;
      rem_q        <= '0;
      id_q         <= '0;
      bus.m_tvalid <= 1'b0;
      bus.m_tlast  <= 1'b0;
      bus.m_tdata  <= '0;
      bus.m_tkeep  <= '0;
      bus.m_tdest  <= '0;
      pkt_count    <= '0;
      drop_count   <= '0;
    end else begin
      if (bus.m_tready) begin
        bus.m_tvalid <= 1'b0;
      end
      unique case (state_q)
        StHdr: begin
          if (accept) begin
            rem_q <= hdr_len;
            id_q  <= hdr_id;
            if (hdr_ok) begin
              state_q <= StPay;
            end else begin
              state_q <= StDrop;
              if (drop_count != '1) drop_count <= drop_count + 32'd1;
            end
          end
        end
        StPay: begin
          if (accept) begin
            rem_q <= rem_q - 16'(B);
            if (out_has) begin
              bus.m_tvalid <= 1'b1;
              bus.m_tdata  <= bus.s_tdata;
              bus.m_tkeep  <= keep_calc;
              bus.m_tlast  <= ({16'd0, out_rem} <= B);
              bus.m_tdest  <= id_q[DEST_W-1:0];
            end
            if (last_in) begin
              state_q <= StHdr;
              if (pkt_count != '1) pkt_count <= pkt_count + 32'd1;
            end
          end
        end
        StDrop: begin
          if (accept) begin
            rem_q <= rem_q - 16'(B);
            if (last_in) state_q <= StHdr;
          end
        end
        default: state_q <= StHdr;
      endcase
    end
  end
endmodule

// File: tb/tb_packet_record_parser.sv
// Self-checking bench for packet_record_parser: random records vs. a per-record beat model.
module tb_packet_record_parser;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned NUM_IF  = 4;
  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1518;
  localparam int unsigned B       = DATA_W / 8;
  localparam int unsigned DEST_W  = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;
  int stalls = 0;
  int exp_pkt = 0;
  int exp_drop = 0;

  logic [DATA_W-1:0] exp_data[$], got_data[$];
  logic [B-1:0]      exp_keep[$], got_keep[$];
  logic              exp_last[$], got_last[$];
  logic [DEST_W-1:0] exp_dest[$], got_dest[$];

  packet_record_parser_if #(.DATA_W(DATA_W), .NUM_IF(NUM_IF)) bus ();

  packet_record_parser #(
    .DATA_W(DATA_W), .NUM_IF(NUM_IF), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    bus.m_tready = 1'b1;
    forever begin
      @(negedge clk);
      bus.m_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Snapshot between edges, commit on the edge where the handshake happens.
  initial begin
    logic              snap;
    logic [DATA_W-1:0] sd;
    logic [B-1:0]      sk;
    logic              sl;
    logic [DEST_W-1:0] st;
    forever begin
      @(negedge clk);
      #1;
      snap = bus.m_tvalid && bus.m_tready && !rst;
      sd = bus.m_tdata; sk = bus.m_tkeep; sl = bus.m_tlast; st = bus.m_tdest;
      @(posedge clk);
      if (snap) begin
        got_data.push_back(sd); got_keep.push_back(sk);
        got_last.push_back(sl); got_dest.push_back(st);
      end
    end
  end

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic clear_queues();
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_dest.delete();
    got_data.delete(); got_keep.delete(); got_last.delete(); got_dest.delete();
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic drive_word(input logic [DATA_W-1:0] w);
    bit rdy;
    bit done;
    done = 1'b0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = w;
    for (int c = 0; c < 2000 && !done; c++) begin
      #1 rdy = bus.s_tready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL drive_timeout s_tready never rose, got=0 required=1");
    end
  endtask

  // Model: a good record yields ceil(olen/B) beats over its first payload words.
  task automatic send_record(input int len, input int id);
    logic [DATA_W-1:0] w;
    logic [63:0]       m;
    int nwords, olen, bytes;
    bit good;
    nwords = (len + B - 1) / B;
    good = (len >= MIN_LEN) && (len <= MAX_LEN) && (id < NUM_IF);
    olen = len;
`ifdef PARSER_STRIP_FCS_EN
    olen = len - 4;
`endif
    w = rand_word();
    w[31:16] = len[15:0];
    w[15:0]  = id[15:0];
    drive_word(w);
    if (good) exp_pkt++;
    else exp_drop++;
    for (int k = 0; k < nwords; k++) begin
      w = rand_word();
      drive_word(w);
      if (good && k * B < olen) begin
        bytes = (olen - k * B >= B) ? B : olen - k * B;
        m = (64'd1 << bytes) - 64'd1;
        exp_data.push_back(w);
        exp_keep.push_back(m[B-1:0]);
        exp_last.push_back((k + 1) * B >= olen);
        exp_dest.push_back(id[DEST_W-1:0]);
      end
    end
  endtask

  task automatic drain();
    bus.s_tvalid = 1'b0;
    for (int c = 0; c < 5000 && got_data.size() < exp_data.size(); c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.s_tready !== 1'b0 || bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b last=%b required 0/0/0",
               bus.s_tready, bus.m_tvalid, bus.m_tlast);
    end
    checks++;
    if (bus.m_tdata !== '0 || bus.m_tkeep !== '0 || bus.m_tdest !== '0) begin
      errors++;
      $display("FAIL reset_data got data=%h keep=%h dest=%0d required 0", bus.m_tdata,
               bus.m_tkeep, bus.m_tdest);
    end
    checks++;
    if (pkt_count !== 32'd0 || drop_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts got pkt=%0d drop=%0d required 0/0", pkt_count, drop_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release s_tready got=%b required=1", bus.s_tready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_queues();
    ready_pct = 100;
    send_record(64, 2);
    drain();
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL basic_beats got=%0d required=%0d", got_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] ||
            got_last[i] !== exp_last[i] || got_dest[i] !== exp_dest[i]) begin
          errors++;
          $display("FAIL basic_beat%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", i, got_data[i],
                   got_keep[i], got_last[i], got_dest[i], exp_data[i], exp_keep[i],
                   exp_last[i], exp_dest[i]);
        end
      end
    end
    checks++;
    if (pkt_count !== 32'd1 || drop_count !== 32'd0) begin
      errors++;
      $display("FAIL basic_counts got pkt=%0d drop=%0d required 1/0", pkt_count, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    ready_pct = 100;
    stalls = 0;
    send_record(65, 0);
    send_record(64, 3);
    drain();
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_stalls got=%0d required=0", stalls);
    end
`ifndef PARSER_STRIP_FCS_EN
    checks++;
    if (got_keep.size() < 9 || got_keep[8] !== 8'h01 || got_last[8] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_odd_tail got beats=%0d required 9+ with keep=01 last=1",
               got_keep.size());
    end
`endif
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL b2b_beats got=%0d required=%0d", got_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] ||
            got_last[i] !== exp_last[i] || got_dest[i] !== exp_dest[i]) begin
          errors++;
          $display("FAIL b2b_beat%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", i, got_data[i],
                   got_keep[i], got_last[i], got_dest[i], exp_data[i], exp_keep[i],
                   exp_last[i], exp_dest[i]);
        end
      end
    end
    checks++;
    if (pkt_count !== 32'(exp_pkt)) begin
      errors++;
      $display("FAIL b2b_pkt_count got=%0d required=%0d", pkt_count, exp_pkt);
    end
  endtask

  task automatic test_drop();
    clear_queues();
    ready_pct = 100;
    send_record(40, 1);
    send_record(100, 5);
    send_record(64, 0);
    drain();
    checks++;
    if (drop_count !== 32'(exp_drop) || pkt_count !== 32'(exp_pkt)) begin
      errors++;
      $display("FAIL drop_counts got pkt=%0d drop=%0d required %0d/%0d", pkt_count, drop_count,
               exp_pkt, exp_drop);
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL drop_beats got=%0d required=%0d", got_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] ||
            got_last[i] !== exp_last[i] || got_dest[i] !== exp_dest[i]) begin
          errors++;
          $display("FAIL drop_beat%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", i, got_data[i],
                   got_keep[i], got_last[i], got_dest[i], exp_data[i], exp_keep[i],
                   exp_last[i], exp_dest[i]);
        end
      end
    end
  endtask

  task automatic test_random_backpressure();
    int len, id;
    clear_queues();
    ready_pct = 50;
    for (int r = 0; r < 100; r++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1400, 1600) : $urandom_range(30, 200);
      id  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 3);
      send_record(len, id);
    end
    drain();
    ready_pct = 100;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL rand_beats got=%0d required=%0d", got_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] ||
            got_last[i] !== exp_last[i] || got_dest[i] !== exp_dest[i]) begin
          errors++;
          $display("FAIL rand_beat%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", i, got_data[i],
                   got_keep[i], got_last[i], got_dest[i], exp_data[i], exp_keep[i],
                   exp_last[i], exp_dest[i]);
        end
      end
    end
    checks++;
    if (pkt_count !== 32'(exp_pkt) || drop_count !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL rand_counts got pkt=%0d drop=%0d required %0d/%0d", pkt_count, drop_count,
               exp_pkt, exp_drop);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [DATA_W-1:0] w;
    clear_queues();
    ready_pct = 0;
    @(negedge clk);
    w = rand_word();
    w[31:0] = 32'h0040_0001;
    drive_word(w);
    drive_word(rand_word());
    bus.s_tvalid = 1'b0;
    #1;
    checks++;
    if (bus.m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre m_tvalid got=%b required=1", bus.m_tvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.m_tvalid !== 1'b0 || pkt_count !== 32'd0 || drop_count !== 32'd0) begin
      errors++;
      $display("FAIL midrst_clear got valid=%b pkt=%0d drop=%0d required 0/0/0", bus.m_tvalid,
               pkt_count, drop_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_pkt = 0;
    exp_drop = 0;
    clear_queues();
    ready_pct = 100;
    @(negedge clk);
    send_record(72, 1);
    drain();
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL midrst_beats got=%0d required=%0d", got_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] ||
            got_last[i] !== exp_last[i] || got_dest[i] !== exp_dest[i]) begin
          errors++;
          $display("FAIL midrst_beat%0d got %h/%h/%b/%0d required %h/%h/%b/%0d", i,
                   got_data[i], got_keep[i], got_last[i], got_dest[i], exp_data[i],
                   exp_keep[i], exp_last[i], exp_dest[i]);
        end
      end
    end
    checks++;
    if (pkt_count !== 32'd1 || drop_count !== 32'd0) begin
      errors++;
      $display("FAIL midrst_counts got pkt=%0d drop=%0d required 1/0", pkt_count, drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_random_backpressure();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
